// File: rtl/sga_rx_comandos.sv
// 8N1 UART receiver with ASCII command decoder for the Snake Game Arcade.
// Emits one-cycle command pulses plus the raw byte, a valid strobe and a framing-error strobe.
module sga_rx_comandos #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic       left,
  output logic       right,
  output logic       up,
  output logic       down,
  output logic       start,
  output logic       pause,
  output logic [7:0] dado,
  output logic       pronto,
  output logic       erro_frame,
  output logic [2:0] db_estado
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    OCIOSO      = 3'd0,
    INICIO      = 3'd1,
    DADOS       = 3'd2,
    PARADA      = 3'd3,
    DECODIFICA  = 3'd4,
    ERRO        = 3'd5,
    ESPERA_IDLE = 3'd6
  } estado_t;

  estado_t       estado;
  logic          rx_m;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Receive FSM; strobes default low so every pulse lasts exactly one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado     <= OCIOSO;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      dado       <= '0;
      pronto     <= 1'b0;
      erro_frame <= 1'b0;
      left       <= 1'b0;
      right      <= 1'b0;
      up         <= 1'b0;
      down       <= 1'b0;
      start      <= 1'b0;
      pause      <= 1'b0;
    end else begin
      pronto     <= 1'b0;
      erro_frame <= 1'b0;
      left       <= 1'b0;
      right      <= 1'b0;
      up         <= 1'b0;
      down       <= 1'b0;
      start      <= 1'b0;
      pause      <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (!rx_s) begin
            estado <= INICIO;
            cnt    <= '0;
          end
        end
        INICIO: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            if (rx_s) begin
              estado <= OCIOSO;
            end else begin
              estado <= DADOS;
              idx    <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DADOS: begin
          if (cnt == BIT_M1) begin
            cnt        <= '0;
            shreg[idx] <= rx_s;
            if (idx == 3'd7) estado <= PARADA;
            else             idx    <= idx + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PARADA: begin
          if (cnt == BIT_M1) begin
            cnt    <= '0;
            estado <= rx_s ? DECODIFICA : ERRO;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DECODIFICA: begin
          dado   <= shreg;
          pronto <= 1'b1;
          case (shreg)
            8'h61, 8'h41: left  <= 1'b1;
            8'h64, 8'h44: right <= 1'b1;
            8'h77, 8'h57: up    <= 1'b1;
            8'h73, 8'h53: down  <= 1'b1;
            8'h69, 8'h49: start <= 1'b1;
            8'h70, 8'h50: pause <= 1'b1;
            default: ;
          endcase
          estado <= OCIOSO;
        end
        ERRO: begin
          erro_frame <= 1'b1;
          estado     <= ESPERA_IDLE;
        end
        ESPERA_IDLE: begin
          // Hold off until the line is released so a break cannot re-trigger.
          if (rx_s) estado <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  assign db_estado = 3'(estado);

endmodule

// File: tb/tb_sga_rx_comandos.sv
// Self-checking bench for sga_rx_comandos: vector table, corner-case sequences,
// then random frames checked against a behavioural decode model.
module tb_sga_rx_comandos;

  localparam int C = 8;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       rx;
  logic       left, right, up, down, start, pause;
  logic [7:0] dado;
  logic       pronto, erro_frame;
  logic [2:0] db_estado;

  sga_rx_comandos #(.CLKS_PER_BIT(C)) dut (
    .clock(clock), .reset_n(reset_n), .rx(rx),
    .left(left), .right(right), .up(up), .down(down),
    .start(start), .pause(pause), .dado(dado),
    .pronto(pronto), .erro_frame(erro_frame), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  logic [5:0] cmds;
  assign cmds = {pause, start, down, up, right, left};

  // Pulse monitor sampled on the falling edge.
  int cyc = 0;
  int n_pronto = 0;
  int n_erro = 0;
  int n_cmd [6];
  int last_cyc [6];
  initial for (int i = 0; i < 6; i++) begin n_cmd[i] = 0; last_cyc[i] = 0; end

  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (reset_n) begin
      if (pronto)     n_pronto <= n_pronto + 1;
      if (erro_frame) n_erro   <= n_erro + 1;
      for (int i = 0; i < 6; i++)
        if (cmds[i]) begin
          n_cmd[i]    <= n_cmd[i] + 1;
          last_cyc[i] <= cyc;
        end
    end
  end

  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural decode: fold upper case to lower, look up the command letter.
  function automatic int model_cmd(input logic [7:0] b);
    string letters = "adwsip";
    logic [7:0] c = b;
    if (c >= 8'h41 && c <= 8'h5A) c = c + 8'd32;
    for (int i = 0; i < 6; i++)
      if (c == letters[i]) return i;
    return -1;
  endfunction

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int extra_low);
    rx = 1'b0;
    repeat (C) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (C) @(negedge clock);
    end
    rx = stop_ok;
    repeat (stop_ok ? C : C + extra_low) @(negedge clock);
    rx = 1'b1;
  endtask

  task automatic check_frame(input string name, input logic [7:0] d, input bit ok,
                             input int exp_cmd, input int exp_pr, input int exp_er,
                             input logic [7:0] exp_dado, input int gap);
    int p0, e0;
    int c0 [6];
    p0 = n_pronto;
    e0 = n_erro;
    for (int i = 0; i < 6; i++) c0[i] = n_cmd[i];
    send_frame(d, ok, 0);
    idle(gap);
    chk({name, " pronto"}, n_pronto - p0, exp_pr);
    chk({name, " erro_frame"}, n_erro - e0, exp_er);
    for (int i = 0; i < 6; i++)
      chk($sformatf("%s cmd%0d", name, i), n_cmd[i] - c0[i], (i == exp_cmd) ? 1 : 0);
    chk({name, " dado"}, int'(dado), int'(exp_dado));
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         exp_cmd;
    int         exp_pronto;
    int         exp_erro;
    logic [7:0] exp_dado;
  } vec_t;

  vec_t vecs [10];
  logic [7:0] exp_dado;
  int p0, e0, t0, u0, d0;
  string cmd_chars = "aAdDwWsSiIpP";

  initial begin
    vecs[0] = '{8'h61, 1'b1,  0, 1, 0, 8'h61};
    vecs[1] = '{8'h44, 1'b1,  1, 1, 0, 8'h44};
    vecs[2] = '{8'h77, 1'b1,  2, 1, 0, 8'h77};
    vecs[3] = '{8'h53, 1'b1,  3, 1, 0, 8'h53};
    vecs[4] = '{8'h49, 1'b1,  4, 1, 0, 8'h49};
    vecs[5] = '{8'h70, 1'b0, -1, 0, 1, 8'h49};
    vecs[6] = '{8'h0D, 1'b1, -1, 1, 0, 8'h0D};
    vecs[7] = '{8'hE1, 1'b1, -1, 1, 0, 8'hE1};
    vecs[8] = '{8'h50, 1'b1,  5, 1, 0, 8'h50};
    vecs[9] = '{8'h0A, 1'b1, -1, 1, 0, 8'h0A};

    reset_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset dado", int'(dado), 0);
    chk("reset strobes", int'({cmds, pronto, erro_frame}), 0);
    chk("reset state", int'(db_estado), 0);
    reset_n = 1'b1;
    idle(4);

    for (int k = 0; k < 10; k++)
      check_frame($sformatf("vec%0d", k), vecs[k].data, vecs[k].stop_ok, vecs[k].exp_cmd,
                  vecs[k].exp_pronto, vecs[k].exp_erro, vecs[k].exp_dado, 6);

    // Back-to-back W then S with no idle gap.
    u0 = n_cmd[2];
    d0 = n_cmd[3];
    send_frame(8'h57, 1'b1, 0);
    send_frame(8'h53, 1'b1, 0);
    idle(6);
    chk("b2b up count", n_cmd[2] - u0, 1);
    chk("b2b down count", n_cmd[3] - d0, 1);
    chk("b2b spacing", last_cyc[3] - last_cyc[2], 80);
    chk("b2b dado", int'(dado), 8'h53);

    // Three-cycle low glitch is rejected.
    p0 = n_pronto;
    e0 = n_erro;
    rx = 1'b0;
    repeat (3) @(negedge clock);
    chk("glitch in INICIO", int'(db_estado), 1);
    idle(20);
    chk("glitch state", int'(db_estado), 0);
    chk("glitch pronto", n_pronto - p0, 0);
    chk("glitch erro", n_erro - e0, 0);

    // Framing error with the line held low afterwards.
    p0 = n_pronto;
    e0 = n_erro;
    t0 = n_cmd[5];
    send_frame(8'h70, 1'b0, 24);
    chk("brk erro", n_erro - e0, 1);
    chk("brk pronto", n_pronto - p0, 0);
    chk("brk pause", n_cmd[5] - t0, 0);
    chk("brk dado", int'(dado), 8'h53);
    rx = 1'b0;
    @(negedge clock);
    chk("brk waiting", int'(db_estado), 6);
    idle(8);
    chk("brk released", int'(db_estado), 0);
    chk("brk single erro", n_erro - e0, 1);

    // Reset during data bit 4 of 'i'.
    p0 = n_pronto;
    e0 = n_erro;
    rx = 1'b0;
    repeat (C) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      rx = 8'h69 >> i;
      repeat (C) @(negedge clock);
    end
    rx = 1'b0;
    repeat (C / 2) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    chk("midrst dado", int'(dado), 0);
    chk("midrst strobes", int'({cmds, pronto, erro_frame}), 0);
    chk("midrst state", int'(db_estado), 0);
    rx = 1'b1;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    idle(2 * C);
    chk("midrst no pronto", n_pronto - p0, 0);
    chk("midrst no erro", n_erro - e0, 0);
    check_frame("after rst i", 8'h69, 1'b1, 4, 1, 0, 8'h69, 6);
    exp_dado = 8'h69;

    // Random frames against the behavioural model.
    for (int k = 0; k < 40; k++) begin
      logic [7:0] b;
      bit ok;
      int gap;
      if ($urandom_range(1) == 0) b = cmd_chars[$urandom_range(11)];
      else                        b = 8'($urandom_range(255));
      ok  = ($urandom_range(7) != 0);
      gap = $urandom_range(20, 4);
      if (ok) exp_dado = b;
      check_frame($sformatf("rnd%0d", k), b, ok, ok ? model_cmd(b) : -1,
                  ok ? 1 : 0, ok ? 0 : 1, exp_dado, gap);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
